// File: rtl/data_mem_responder.sv
// Data-port responder for the single-cycle MIPS core: word RAM plus an MMIO
// window holding a byte transmit FIFO, a status register and a cycle counter.
module data_mem_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [31:0]   cycles;

  logic          mmio_sel, is_tx, is_status, is_cycles;
  logic [AW-1:0] ram_idx;
  logic          empty, full, push_req, push_ok, pop, ovf_clear, ovf_set;
  logic [7:0]    count8;
  logic [31:0]   status_word;
  logic          unused_addr_lsbs;

  // Byte offset bits never take part in decode; all accesses are whole words.
  assign unused_addr_lsbs = ^aluout[1:0];

  assign mmio_sel  = (aluout[31:16] == MMIO_BASE[31:16]);
  assign is_tx     = mmio_sel && (aluout[15:2] == 14'd0);
  assign is_status = mmio_sel && (aluout[15:2] == 14'd1);
  assign is_cycles = mmio_sel && (aluout[15:2] == 14'd2);
  assign ram_idx   = aluout[AW+1:2];

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign pop       = out_valid && out_ready;
  assign push_req  = memwrite && is_tx;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign ovf_set   = push_req && !push_ok;
  assign ovf_clear = memwrite && is_status && writedata[2];

  assign count8      = 8'(count);
  assign status_word = {16'h0000, count8, 5'b00000, overflow, full, empty};

  assign out_valid = !empty;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (memwrite && !mmio_sel) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A fresh rejection wins over a simultaneous clear.
      overflow <= ovf_set || (overflow && !ovf_clear);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     cycles <= '0;
    else if (memwrite && is_cycles) cycles <= writedata;
    else                            cycles <= cycles + 32'd1;
  end

  always_comb begin
    readdata = 32'h0;
    if (!mmio_sel)      readdata = ram[ram_idx];
    else if (is_status) readdata = status_word;
    else if (is_cycles) readdata = cycles;
  end

endmodule
